// File: rtl/uart_tx_stream_pkg.sv
// Shared definitions for the streaming UART transmitter: FSM encodings,
// parity-type encodings and default geometry.
package uart_tx_stream_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultFifoDepth = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  typedef enum logic {
    ParEven = 1'b0,
    ParOdd  = 1'b1
  } par_typ_e;

  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == ParOdd) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream feeding the UART transmitter.
interface uart_tx_stream_if
  import uart_tx_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
);

  logic [DATA_WIDTH-1:0] S_DATA;
  logic                  S_VALID;
  logic                  S_READY;

  modport master (
    output S_DATA,
    output S_VALID,
    input  S_READY
  );

  modport slave (
    input  S_DATA,
    input  S_VALID,
    output S_READY
  );

endinterface

// File: rtl/uart_tx_sfifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth so pointers wrap
// naturally. Synchronous active-high reset flushes the contents.
module uart_tx_sfifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  localparam logic [LevelW-1:0] FullLevel = LevelW'(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == FullLevel);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against protocol misuse so the count can never wrap.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a buffered valid/ready stream. Frame settings are
// latched when a word is popped, so config changes only affect later frames.
module uart_tx_stream
  import uart_tx_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned PRESCALE_W = 16,
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  uart_tx_stream_if.slave       s_if,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [LevelW-1:0]     FIFO_LEVEL
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] timer_q, timer_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d, eff_presc;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end, load;

  assign s_if.S_READY = ~fifo_full & ~RST;
  assign fifo_push    = s_if.S_VALID & s_if.S_READY;
  assign eff_presc    = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
  assign bit_end      = (timer_q == '0);

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

  uart_tx_sfifo #(
    .Width (DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .wdata_i (s_if.S_DATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (FIFO_LEVEL)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    load      = 1'b0;
    fifo_pop  = 1'b0;

    // Line and busy reflect the state being held this cycle, then register.
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
        if (bit_end) begin
          state_d = StData;
          timer_d = presc_q - PRESCALE_W'(1);
          cnt_d   = '0;
        end else begin
          timer_d = timer_q - PRESCALE_W'(1);
        end
      end
      StData: begin
        tx_d   = shreg_q[0];
        busy_d = 1'b1;
        if (bit_end) begin
          timer_d = presc_q - PRESCALE_W'(1);
          shreg_d = shreg_q >> 1;
          if (cnt_q == LastBit) begin
            state_d = par_en_q ? StParity : StStop;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          timer_d = timer_q - PRESCALE_W'(1);
        end
      end
      StParity: begin
        tx_d   = par_bit_q;
        busy_d = 1'b1;
        if (bit_end) begin
          state_d = StStop;
          timer_d = presc_q - PRESCALE_W'(1);
          cnt_d   = '0;
        end else begin
          timer_d = timer_q - PRESCALE_W'(1);
        end
      end
      StStop: begin
        busy_d = 1'b1;
        if (bit_end) begin
          if (stop2_q && (cnt_q == '0)) begin
            cnt_d   = CntW'(1);
            timer_d = presc_q - PRESCALE_W'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          timer_d = timer_q - PRESCALE_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase

    // Pop and latch the whole frame context in one go.
    if (load) begin
      fifo_pop  = 1'b1;
      state_d   = StStart;
      timer_d   = eff_presc - PRESCALE_W'(1);
      cnt_d     = '0;
      shreg_d   = fifo_rdata;
      presc_d   = eff_presc;
      par_en_d  = PAR_EN;
      par_bit_d = parity_bit(^fifo_rdata, PAR_TYP);
      stop2_d   = STOP2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      presc_q   <= PRESCALE_W'(1);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed self-checking bench for uart_tx_stream (8 data bits, 4-deep FIFO).
module tb_uart_tx_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned PW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [PW-1:0] PRESCALE;
  logic          PAR_EN, PAR_TYP, STOP2;
  logic          TX_OUT, BUSY;
  logic [2:0]    FIFO_LEVEL;

  int checks   = 0;
  int failures = 0;

  uart_tx_stream_if #(.DATA_WIDTH(DW)) s_if ();

  uart_tx_stream #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .PRESCALE_W (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .s_if       (s_if),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    s_if.S_DATA  = d;
    s_if.S_VALID = 1'b1;
    step();
    s_if.S_VALID = 1'b0;
  endtask

  task automatic wait_start(input string nm, input int limit);
    int n = 0;
    while (TX_OUT !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (TX_OUT !== 1'b0) begin
      failures++;
      $display("FAIL %s start: TX_OUT=%b after %0d cycles, expected 0", nm, TX_OUT, limit);
    end
  endtask

  // Called on the first cycle of START as seen on TX_OUT; returns just after the frame.
  task automatic frame_check(input logic [7:0] w, input int p, input bit pe, input bit pt,
                             input bit s2, input string nm);
    int pp;
    bit bits[$];
    pp = (p == 0) ? 1 : p;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (pe) bits.push_back((^w) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < pp; c++) begin
        checks++;
        if (TX_OUT !== bits[k]) begin
          failures++;
          $display("FAIL %s bit%0d cyc%0d: TX_OUT=%b expected %b", nm, k, c, TX_OUT, bits[k]);
        end
        checks++;
        if (BUSY !== 1'b1) begin
          failures++;
          $display("FAIL %s busy bit%0d cyc%0d: BUSY=%b expected 1", nm, k, c, BUSY);
        end
        step();
      end
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (BUSY !== 1'b0 || TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL %s idle: BUSY=%b TX_OUT=%b expected BUSY=0 TX_OUT=1", nm, BUSY, TX_OUT);
    end
  endtask

  task automatic test_reset();
    RST          = 1'b1;
    s_if.S_VALID = 1'b1;
    s_if.S_DATA  = 8'h5A;
    PRESCALE     = 16'd1;
    PAR_EN       = 1'b1;
    PAR_TYP      = 1'b0;
    STOP2        = 1'b0;
    repeat (3) step();
    check_idle("reset");
    checks++;
    if (FIFO_LEVEL !== 3'd0) begin
      failures++;
      $display("FAIL reset level: FIFO_LEVEL=%0d expected 0", FIFO_LEVEL);
    end
    checks++;
    if (s_if.S_READY !== 1'b0) begin
      failures++;
      $display("FAIL reset ready: S_READY=%b expected 0", s_if.S_READY);
    end
    s_if.S_VALID = 1'b0;
    RST          = 1'b0;
    step();
    checks++;
    if (s_if.S_READY !== 1'b1 || FIFO_LEVEL !== 3'd0) begin
      failures++;
      $display("FAIL reset release: S_READY=%b FIFO_LEVEL=%0d expected 1 and 0",
               s_if.S_READY, FIFO_LEVEL);
    end
  endtask

  task automatic test_basic_frame();
    PRESCALE = 16'd1; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    push_one(8'hA5);
    checks++;
    if (FIFO_LEVEL !== 3'd1) begin
      failures++;
      $display("FAIL latency level: FIFO_LEVEL=%0d expected 1", FIFO_LEVEL);
    end
    check_idle("latency_t");
    step();
    checks++;
    if (FIFO_LEVEL !== 3'd0) begin
      failures++;
      $display("FAIL latency pop: FIFO_LEVEL=%0d expected 0", FIFO_LEVEL);
    end
    check_idle("latency_t1");
    step();
    frame_check(8'hA5, 1, 1'b1, 1'b0, 1'b0, "basic_a5");
    check_idle("basic_end");
  endtask

  task automatic test_prescale16();
    PRESCALE = 16'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    push_one(8'h00);
    wait_start("p16", 5);
    frame_check(8'h00, 16, 1'b1, 1'b1, 1'b0, "p16_odd");
    check_idle("p16_end");
  endtask

  task automatic test_back_to_back();
    PRESCALE = 16'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
    s_if.S_DATA  = 8'hFF;
    s_if.S_VALID = 1'b1;
    step();
    s_if.S_DATA = 8'h0F;
    step();
    s_if.S_VALID = 1'b0;
    checks++;
    if (FIFO_LEVEL !== 3'd1) begin
      failures++;
      $display("FAIL push_pop_same_edge: FIFO_LEVEL=%0d expected 1", FIFO_LEVEL);
    end
    wait_start("b2b", 5);
    frame_check(8'hFF, 4, 1'b0, 1'b0, 1'b1, "b2b_ff");
    frame_check(8'h0F, 4, 1'b0, 1'b0, 1'b1, "b2b_0f");
    check_idle("b2b_end");
  endtask

  task automatic test_fifo_full();
    logic [7:0] words [10];
    int         idx = 0;
    bit         saw_full = 1'b0;
    PRESCALE = 16'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    for (int i = 0; i < 10; i++) words[i] = 8'(i * 37 + 3);
    fork
      begin
        logic rdy;
        for (int cyc = 0; cyc < 600 && idx < 10; cyc++) begin
          s_if.S_VALID = 1'b1;
          s_if.S_DATA  = words[idx];
          rdy = s_if.S_READY;
          checks++;
          if (FIFO_LEVEL == 3'd4) begin
            saw_full = 1'b1;
            if (rdy !== 1'b0) begin
              failures++;
              $display("FAIL full ready: S_READY=%b at level 4, expected 0", rdy);
            end
          end else if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL notfull ready: S_READY=%b at level %0d, expected 1", rdy, FIFO_LEVEL);
          end
          step();
          if (rdy) idx++;
        end
        s_if.S_VALID = 1'b0;
      end
      begin
        logic [7:0] got;
        for (int f = 0; f < 10; f++) begin
          wait_start("full_frame", (f == 0) ? 10 : 1);
          got = '0;
          repeat (6) step();
          for (int i = 0; i < 8; i++) begin
            got[i] = TX_OUT;
            repeat ((i == 7) ? 6 : 4) step();
          end
          checks++;
          if (got !== words[f]) begin
            failures++;
            $display("FAIL full word%0d: received %h expected %h", f, got, words[f]);
          end
        end
      end
    join
    checks++;
    if (idx != 10 || !saw_full) begin
      failures++;
      $display("FAIL full accept: accepted=%0d saw_full=%0d expected 10 and 1", idx, saw_full);
    end
    check_idle("full_end");
  endtask

  task automatic test_reset_mid();
    PRESCALE = 16'd4; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    s_if.S_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.S_DATA = 8'(8'h71 + i);
      step();
    end
    s_if.S_VALID = 1'b0;
    wait_start("rstmid", 5);
    repeat (10) step();
    checks++;
    if (FIFO_LEVEL !== 3'd2 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL rstmid pre: FIFO_LEVEL=%0d BUSY=%b expected 2 and 1", FIFO_LEVEL, BUSY);
    end
    RST = 1'b1;
    step();
    check_idle("rstmid_edge");
    checks++;
    if (FIFO_LEVEL !== 3'd0 || s_if.S_READY !== 1'b0) begin
      failures++;
      $display("FAIL rstmid flush: FIFO_LEVEL=%0d S_READY=%b expected 0 and 0",
               FIFO_LEVEL, s_if.S_READY);
    end
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_LEVEL !== 3'd0) begin
        failures++;
        $display("FAIL rstmid quiet cyc%0d: TX_OUT=%b BUSY=%b FIFO_LEVEL=%0d expected 1 0 0",
                 i, TX_OUT, BUSY, FIFO_LEVEL);
      end
    end
    push_one(8'hC3);
    wait_start("rstmid_new", 5);
    frame_check(8'hC3, 4, 1'b1, 1'b0, 1'b0, "rstmid_c3");
    check_idle("rstmid_end");
  endtask

  task automatic test_cfg_change();
    PRESCALE = 16'd0; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    s_if.S_DATA  = 8'h3C;
    s_if.S_VALID = 1'b1;
    step();
    s_if.S_DATA = 8'h81;
    step();
    s_if.S_VALID = 1'b0;
    wait_start("cfg", 5);
    PAR_EN = 1'b0;
    frame_check(8'h3C, 0, 1'b1, 1'b0, 1'b0, "p0_first");
    frame_check(8'h81, 0, 1'b0, 1'b0, 1'b0, "cfg_next");
    check_idle("cfg_end");
  endtask

  initial begin
    s_if.S_VALID = 1'b0;
    s_if.S_DATA  = '0;
    test_reset();
    test_basic_frame();
    test_prescale16();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_cfg_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Parametrised next-generation UART transmitter: configurable data width, runtime baud prescale, optional even/odd parity, 1 or 2 stop bits.
Input side is a valid/ready stream buffered by an internal FIFO, so a host can queue several words for back-to-back frames with no gap.
Sits between the host/register interface and the serial pin; same frame format as the current transmitter when PRESCALE=1, PAR_EN=1, STOP2=0.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
FIFO_DEPTH, 4, input buffer entries (power of 2, >=2).
PRESCALE_W, 16, width of the PRESCALE input.

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
PRESCALE  in  PRESCALE_W  CLK cycles per serial bit; 0 treated as 1
PAR_EN  in  1  1 = insert parity bit after data
PAR_TYP  in  1  0 = even, 1 = odd parity
STOP2  in  1  1 = two stop bits, 0 = one
S_DATA  in  DATA_WIDTH  word to transmit
S_VALID  in  1  S_DATA valid
S_READY  out  1  FIFO can accept; transfer when S_VALID && S_READY
TX_OUT  out  1  serial line, idle high
BUSY  out  1  high while a frame is in progress (START through last STOP)
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  words queued, not yet started

Behaviour:
- Reset (RST high at an edge): TX_OUT=1, BUSY=0, FIFO_LEVEL=0, S_READY=0 while RST is high, FSM->IDLE, FIFO flushed, bit timer and bit counter cleared. Applies mid-frame: line returns high on the next edge; partial frame is abandoned, never resumed.
- S_READY = (FIFO_LEVEL != FIFO_DEPTH) && !RST. A push when full is impossible by construction; S_VALID with S_READY=0 has no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. If FIFO non-empty: pop head, latch word, PAR_EN, PAR_TYP, STOP2, PRESCALE (0->1) into frame registers, compute parity, -> START.
- Parity: even = XOR of data bits; odd = inverted XOR. Computed from the latched word only.
- START: TX_OUT=0 for PRESCALE cycles -> DATA.
- DATA: LSB first, each bit PRESCALE cycles; after bit DATA_WIDTH-1 -> PARITY if latched PAR_EN else STOP.
- PARITY: TX_OUT=parity bit, PRESCALE cycles -> STOP.
- STOP: TX_OUT=1 for PRESCALE cycles (2*PRESCALE if latched STOP2). At end: if FIFO non-empty, pop and go directly to START (no idle cycle); else -> IDLE.
- BUSY high in START, DATA, PARITY, STOP; low only in IDLE.
- Frame length = (2 + DATA_WIDTH + PAR_EN + STOP2) * PRESCALE cycles exactly.
- Latency: word accepted at edge t into empty FIFO with FSM idle -> FIFO_LEVEL=1 after t, popped at t+1, TX_OUT falls at t+2.
- Push and internal pop at the same edge: both take effect; FIFO_LEVEL unchanged.
- Config inputs changed mid-frame affect only the next frame.
- TX_OUT, BUSY are registered outputs, glitch-free.
- Bit timer counts PRESCALE-1 down to 0; bit counter wraps to 0 at each state change.

Decomposition:
- Shared config include: FSM state encodings (3-bit), default DATA_WIDTH/FIFO_DEPTH, parity-type encodings (EVEN=0, ODD=1).
- One sub-module: uart_tx_sfifo (synchronous FIFO, DATA_WIDTH x FIFO_DEPTH, push/pop/level, sync active-high reset on RST).
- FSM, bit timer, shift register and parity in the top module.

Test Plan:
- PRESCALE=1, PAR_EN=1, PAR_TYP=0, STOP2=0, push 0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, even parity 0, stop); 11 cycles; BUSY high for exactly 11 cycles.
- PRESCALE=16, PAR_EN=1, PAR_TYP=1, push 0x00 -> each bit held 16 cycles; parity bit=1; frame 176 cycles.
- PAR_EN=0, STOP2=1, PRESCALE=4, push 0xFF,0x0F back-to-back -> two frames of 44 cycles each, second start bit immediately after first frame's 8 stop-bit cycles, BUSY never drops between them.
- Hold S_VALID, FIFO_DEPTH=4, frame in progress -> S_READY drops after 4 queued words (FIFO_LEVEL=4), rises the cycle after the next pop; no word lost or duplicated over 10 words.
- Assert RST mid-DATA of a frame with 2 words queued -> next edge TX_OUT=1, BUSY=0, FIFO_LEVEL=0; after release, idle line until a new push.
- PRESCALE=0 -> behaves as PRESCALE=1; change PAR_EN during a frame -> current frame unaffected, next frame uses new setting.
